// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Purpose  : Game-clock countdown. Loads a second count (clamped to MAX_SEC),
//            decrements it once every CLK_HZ running cycles while enabled,
//            and flags expiry for the HUD display and game-over logic.
// Ports    : clk_100mhz_in  - system clock
//            rst_n_in       - asynchronous active-low reset
//            load_in        - 1-cycle pulse: load start_sec_in, abort any run
//            start_sec_in   - seconds to load (sampled only with load_in)
//            run_in         - level: 1 = count down, 0 = pause
//            time_out       - seconds remaining (registered)
//            tick_out       - 1-cycle pulse on each decrement
//            done_out       - 1-cycle pulse when time_out reaches 0 by counting
//            expired_out    - sticky expiry flag, cleared by the next load
//            state_out      - 0=IDLE 1=RUNNING 2=PAUSED 3=EXPIRED
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SEC_WIDTH = 10,
  parameter int MAX_SEC   = 999
) (
  input  logic                 clk_100mhz_in,
  input  logic                 rst_n_in,
  input  logic                 load_in,
  input  logic [SEC_WIDTH-1:0] start_sec_in,
  input  logic                 run_in,
  output logic [SEC_WIDTH-1:0] time_out,
  output logic                 tick_out,
  output logic                 done_out,
  output logic                 expired_out,
  output logic [1:0]           state_out
);

  // Prescaler needs to hold 0..CLK_HZ-1; keep at least one bit for CLK_HZ=1.
  localparam int                 c_PRESC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_TERM = c_PRESC_W'(CLK_HZ - 1);
  localparam logic [SEC_WIDTH-1:0] c_MAX_SEC    = SEC_WIDTH'(MAX_SEC);
  localparam logic [SEC_WIDTH-1:0] c_ONE_SEC    = SEC_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t                 r_state;
  logic [c_PRESC_W-1:0]   r_presc;
  logic [SEC_WIDTH-1:0]   r_time;
  logic                   r_tick;
  logic                   r_done;
  logic                   r_expired;

  logic [SEC_WIDTH-1:0]   w_load_val;

  assign w_load_val = (start_sec_in > c_MAX_SEC) ? c_MAX_SEC : start_sec_in;

  always_ff @(posedge clk_100mhz_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_time    <= '0;
      r_tick    <= 1'b0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      // Pulses are only ever raised in a decrement cycle.
      r_tick <= 1'b0;
      r_done <= 1'b0;

      if (load_in) begin
        // Load wins over everything and discards any partial second.
        r_time    <= w_load_val;
        r_presc   <= '0;
        r_expired <= 1'b0;
        r_state   <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (run_in && (r_time != '0)) begin
              r_state <= ST_RUNNING;
            end
          end

          ST_RUNNING: begin
            if (!run_in) begin
              // Prescaler holds so the partial second resumes later.
              r_state <= ST_PAUSED;
            end else if (r_presc == c_PRESC_TERM) begin
              r_presc <= '0;
              r_time  <= r_time - c_ONE_SEC;
              r_tick  <= 1'b1;
              if (r_time == c_ONE_SEC) begin
                r_done    <= 1'b1;
                r_expired <= 1'b1;
                r_state   <= ST_EXPIRED;
              end
            end else begin
              r_presc <= r_presc + c_PRESC_W'(1);
            end
          end

          ST_PAUSED: begin
            if (run_in) begin
              r_state <= ST_RUNNING;
            end
          end

          ST_EXPIRED: begin
            // Only a load leaves this state.
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign time_out    = r_time;
  assign tick_out    = r_tick;
  assign done_out    = r_done;
  assign expired_out = r_expired;
  assign state_out   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer
// Purpose  : Self-checking bench for countdown_timer (CLK_HZ=4, MAX_SEC=999).
//            A behavioural model tracks remaining seconds and elapsed cycles
//            inside the current second; outputs are compared every cycle.
//            Directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

  localparam int CLK_HZ    = 4;
  localparam int SEC_WIDTH = 10;
  localparam int MAX_SEC   = 999;

  logic                 clk;
  logic                 rst_n;
  logic                 load;
  logic [SEC_WIDTH-1:0] start_sec;
  logic                 run;
  logic [SEC_WIDTH-1:0] time_o;
  logic                 tick_o;
  logic                 done_o;
  logic                 expired_o;
  logic [1:0]           state_o;

  int checks   = 0;
  int failures = 0;

  countdown_timer #(
    .CLK_HZ   (CLK_HZ),
    .SEC_WIDTH(SEC_WIDTH),
    .MAX_SEC  (MAX_SEC)
  ) dut (
    .clk_100mhz_in(clk),
    .rst_n_in     (rst_n),
    .load_in      (load),
    .start_sec_in (start_sec),
    .run_in       (run),
    .time_out     (time_o),
    .tick_out     (tick_o),
    .done_out     (done_o),
    .expired_out  (expired_o),
    .state_out    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // mode: 0 idle, 1 counting, 2 paused, 3 expired
  int m_secs;
  int m_elapsed;
  int m_mode;
  int m_tick;
  int m_done;

  always @(posedge clk or negedge rst_n) begin
    int secs, elapsed, mode, tk, dn;
    if (!rst_n) begin
      m_secs    <= 0;
      m_elapsed <= 0;
      m_mode    <= 0;
      m_tick    <= 0;
      m_done    <= 0;
    end else begin
      secs = m_secs; elapsed = m_elapsed; mode = m_mode; tk = 0; dn = 0;
      if (load) begin
        secs    = (int'(start_sec) > MAX_SEC) ? MAX_SEC : int'(start_sec);
        elapsed = 0;
        mode    = 0;
      end else if (mode == 1 && run) begin
        elapsed = elapsed + 1;
        if (elapsed == CLK_HZ) begin
          elapsed = 0;
          secs    = secs - 1;
          tk      = 1;
          if (secs == 0) begin
            dn   = 1;
            mode = 3;
          end
        end
      end else if (mode == 1) begin
        mode = 2;
      end else if (run && ((mode == 0 && secs > 0) || mode == 2)) begin
        mode = 1;
      end
      m_secs    <= secs;
      m_elapsed <= elapsed;
      m_mode    <= mode;
      m_tick    <= tk;
      m_done    <= dn;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_time",    int'(time_o),    m_secs);
      chk("model_tick",    int'(tick_o),    m_tick);
      chk("model_done",    int'(done_o),    m_done);
      chk("model_expired", int'(expired_o), (m_mode == 3) ? 1 : 0);
      chk("model_state",   int'(state_o),   m_mode);
    end
  end

  // --------------------------------------------------------------- driver
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int val, input logic r);
    load      = 1'b1;
    start_sec = SEC_WIDTH'(val);
    run       = r;
    cyc();
    load      = 1'b0;
  endtask

  initial begin
    load      = 1'b0;
    start_sec = '0;
    run       = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_time",  int'(time_o), 0);
    chk("reset_state", int'(state_o), 0);
    rst_n = 1'b1;
    cyc();

    // Load 3 and run to expiry: tick every 4 cycles, done with the last.
    do_load(3, 1'b1);
    chk("t2_load_time",  int'(time_o), 3);
    chk("t2_load_state", int'(state_o), 0);
    cyc();
    chk("t2_run_state", int'(state_o), 1);
    for (int k = 1; k <= 3; k++) begin
      repeat (3) begin
        cyc();
        chk("t2_no_tick", int'(tick_o), 0);
      end
      cyc();
      chk("t2_tick", int'(tick_o), 1);
      chk("t2_time", int'(time_o), 3 - k);
      chk("t2_done", int'(done_o), (k == 3) ? 1 : 0);
    end
    chk("t2_expired", int'(expired_o), 1);
    chk("t2_state",   int'(state_o), 3);
    cyc();
    chk("t2_done_pulse", int'(done_o), 0);

    // Expired ignores run; load 7 clears expiry.
    for (int k = 0; k < 6; k++) begin
      run = k[0];
      cyc();
      chk("t6_hold_time",  int'(time_o), 0);
      chk("t6_hold_state", int'(state_o), 3);
    end
    do_load(7, 1'b0);
    chk("t6_time",    int'(time_o), 7);
    chk("t6_expired", int'(expired_o), 0);
    chk("t6_state",   int'(state_o), 0);

    // Pause holds partial second; resume after 2 more running cycles.
    do_load(5, 1'b1);
    cyc();
    repeat (4) cyc();
    chk("t3_first_tick", int'(time_o), 4);
    repeat (2) cyc();
    run = 1'b0;
    cyc();
    chk("t3_paused", int'(state_o), 2);
    repeat (9) begin
      cyc();
      chk("t3_hold_time", int'(time_o), 4);
      chk("t3_hold_tick", int'(tick_o), 0);
    end
    run = 1'b1;
    cyc();
    chk("t3_resume_state", int'(state_o), 1);
    cyc();
    chk("t3_pre_tick", int'(tick_o), 0);
    cyc();
    chk("t3_resume_tick", int'(tick_o), 1);
    chk("t3_resume_time", int'(time_o), 3);

    // Clamp, and zero load stays idle.
    do_load(1023, 1'b0);
    chk("t4_clamp", int'(time_o), 999);
    do_load(0, 1'b1);
    repeat (5) begin
      cyc();
      chk("t4_zero_state", int'(state_o), 0);
      chk("t4_zero_done",  int'(done_o), 0);
      chk("t4_zero_time",  int'(time_o), 0);
    end

    // Load on a prescaler terminal cycle.
    do_load(3, 1'b1);
    cyc();
    repeat (3) cyc();
    do_load(2, 1'b1);
    chk("t5_time",  int'(time_o), 2);
    chk("t5_tick",  int'(tick_o), 0);
    chk("t5_state", int'(state_o), 0);
    cyc();
    repeat (3) begin
      cyc();
      chk("t5_no_tick", int'(tick_o), 0);
    end
    cyc();
    chk("t5_tick_restart", int'(tick_o), 1);
    chk("t5_time_after",   int'(time_o), 1);

    // Asynchronous reset mid-run.
    do_load(6, 1'b1);
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    chk("t1_time",    int'(time_o), 0);
    chk("t1_tick",    int'(tick_o), 0);
    chk("t1_done",    int'(done_o), 0);
    chk("t1_expired", int'(expired_o), 0);
    chk("t1_state",   int'(state_o), 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Randomized traffic, checked by the model every cycle.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 4) begin
        load = 1'b1;
        case ($urandom_range(0, 9))
          0:       start_sec = 10'd1023;
          1:       start_sec = 10'd1000;
          2:       start_sec = 10'd0;
          default: start_sec = SEC_WIDTH'($urandom_range(1, 6));
        endcase
      end else begin
        load      = 1'b0;
        start_sec = SEC_WIDTH'($urandom);
      end
      if ($urandom_range(0, 99) < 12) run = ~run;
      cyc();
    end
    load = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
